draw_goalkeeper: RTL



---
 rtl/keeper_pkg.sv | 30 +++
 rtl/signal_delay.sv | 29 ++
 rtl/draw_goalkeeper.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/keeper_pkg.sv
// Shared types and constants for the goalkeeper sprite overlay stage.
package keeper_pkg;

    localparam int unsigned CNT_W            = 11;
    localparam int unsigned RGB_W            = 12;
    localparam int unsigned ROW_ADDR_W       = 20;
    localparam int unsigned SPRITE_W_DEFAULT = 200;
    localparam int unsigned SPRITE_H_DEFAULT = 300;
    localparam int unsigned PIPE_LATENCY     = 3;
    localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 12'hF0F;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             hblnk;
        logic             vsync;
        logic             vblnk;
    } vga_timing_t;

    localparam int unsigned TIMING_W = $bits(vga_timing_t);

    // Row base address for a 200-pixel-wide sprite: dy*200 = dy*(128+64+8).
    function automatic logic [ROW_ADDR_W-1:0] times_200(input logic [CNT_W-1:0] dy);
        logic [ROW_ADDR_W-1:0] d;
        d = ROW_ADDR_W'(dy);
        return (d << 7) + (d << 6) + (d << 3);
    endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-depth register delay line with synchronous clear.
module signal_delay #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] pipe_q [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CLK_DEL); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din_i;
            for (int i = 1; i < int'(CLK_DEL); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_goalkeeper.sv
// Goalkeeper sprite overlay: ROM addressing, 3-cycle aligned compositing.
// Define KEEPER_TRANSPARENCY_EN to treat TRANSPARENT_KEY pixels as see-through.
module draw_goalkeeper
    import keeper_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned SPRITE_W   = SPRITE_W_DEFAULT,
    parameter int unsigned SPRITE_H   = SPRITE_H_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [10:0]           xpos,
    input  logic [10:0]           ypos,
    input  logic                  keeper_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [10:0]           hcount_out,
    output logic [10:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  hblnk_out,
    output logic                  vsync_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out
);

`ifdef KEEPER_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    localparam int unsigned DLY_W = TIMING_W + RGB_W + 1;

    logic             vblnk_prev_q;
    logic [CNT_W-1:0] x_l_q;
    logic [CNT_W-1:0] y_l_q;
    logic             en_l_q;
    logic             vblank_rise_c;

    // Position is only sampled on the vblank rising edge so a frame never tears.
    assign vblank_rise_c = vblnk_in && !vblnk_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_q <= 1'b0;
            x_l_q        <= '0;
            y_l_q        <= '0;
            en_l_q       <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            if (vblank_rise_c) begin
                x_l_q  <= xpos;
                y_l_q  <= ypos;
                en_l_q <= keeper_en;
            end
        end
    end

    logic [CNT_W:0]          h_ext, v_ext, x_ext, y_ext;
    logic [CNT_W-1:0]        dx_c, dy_c;
    logic [ROW_ADDR_W-1:0]   row_c;
    logic                    in_box_c;
    logic [ADDR_WIDTH-1:0]   rom_addr_d, rom_addr_q;

    // Box test in 12 bits so a right/bottom edge past 2047 cannot wrap around.
    always_comb begin
        h_ext      = {1'b0, hcount_in};
        v_ext      = {1'b0, vcount_in};
        x_ext      = {1'b0, x_l_q};
        y_ext      = {1'b0, y_l_q};
        in_box_c   = en_l_q
                     && (h_ext >= x_ext) && (h_ext < x_ext + (CNT_W+1)'(SPRITE_W))
                     && (v_ext >= y_ext) && (v_ext < y_ext + (CNT_W+1)'(SPRITE_H));
        dx_c       = hcount_in - x_l_q;
        dy_c       = vcount_in - y_l_q;
        row_c      = (SPRITE_W == 200) ? times_200(dy_c)
                                       : ROW_ADDR_W'(32'(dy_c) * SPRITE_W);
        rom_addr_d = '0;
        if (in_box_c) begin
            rom_addr_d = ADDR_WIDTH'(row_c) + ADDR_WIDTH'(dx_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr = rom_addr_q;

    vga_timing_t       timing_c, dly_timing, timing_q;
    logic [RGB_W-1:0]  dly_rgb;
    logic              dly_in_box;
    logic [DLY_W-1:0]  dly_bus;

    assign timing_c = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

    // Two cycles brings the side-band in line with the registered ROM output.
    signal_delay #(
        .WIDTH   (DLY_W),
        .CLK_DEL (PIPE_LATENCY - 1)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .din_i  ({timing_c, rgb_in, in_box_c}),
        .dout_o (dly_bus)
    );

    assign {dly_timing, dly_rgb, dly_in_box} = dly_bus;

    logic [RGB_W-1:0] rom_rgb_c;
    logic             is_key_c;
    logic [RGB_W-1:0] rgb_d, rgb_q;

    always_comb begin
        rom_rgb_c = RGB_W'(rom_data);
        is_key_c  = (rom_rgb_c == TRANSPARENT_KEY);
        rgb_d     = dly_rgb;
        if (dly_timing.hblnk || dly_timing.vblnk) begin
            rgb_d = '0;
        end else if (dly_in_box && !(TRANSP_EN && is_key_c)) begin
            rgb_d = rom_rgb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timing_q <= '0;
            rgb_q    <= '0;
        end else begin
            timing_q <= dly_timing;
            rgb_q    <= rgb_d;
        end
    end

    assign hcount_out = timing_q.hcount;
    assign vcount_out = timing_q.vcount;
    assign hsync_out  = timing_q.hsync;
    assign hblnk_out  = timing_q.hblnk;
    assign vsync_out  = timing_q.vsync;
    assign vblnk_out  = timing_q.vblnk;
    assign rgb_out    = rgb_q;

endmodule
